// File: rtl/mem_io_bridge.sv
// mem_io_bridge: LC-3 bus to SRAM bridge with req/ack handshake, programmable
// SRAM wait states and memory-mapped I/O (switches, hex digits, LEDs).
// Optional feature macro: SW_SYNC_EN (2-flop synchronizer on Switches).

// One hex digit register; instantiated once per digit.
module mem_io_hex_digit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       we,
  input  logic [3:0] d,
  output logic [3:0] q
);
  // Digit nibble, loaded when its bank is written.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset)   q <= '0;
    else if (we) q <= d;
endmodule

module mem_io_bridge #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 20,
  parameter int                NUM_HEX     = 4,
  parameter int                WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] IO_BASE     = 20'hFFFF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic                  busy,
  input  logic [DATA_W-1:0]     Switches,
  output logic [NUM_HEX*4-1:0]  hex_digits,
  output logic [11:0]           LED,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_ce_n,
  output logic                  mem_oe_n,
  output logic                  mem_we_n,
  output logic [DATA_W-1:0]     mem_dq_o,
  output logic                  mem_dq_oe,
  input  logic [DATA_W-1:0]     mem_dq_i
);
  localparam logic [ADDR_W-1:0] IO_HEX1 = IO_BASE - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IO_LED  = IO_BASE - ADDR_W'(2);
  localparam logic [3:0]        WS      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                   state;
  req_t                     cur;
  logic [3:0]               cnt;
  logic [NUM_HEX-1:0][3:0]  hex_q;
  logic [DATA_W-1:0]        sw_val;
  logic [DATA_W-1:0]        io_rd;
  logic [15:0]              bank1;
  logic                     io_hit;
  logic                     hex0_we;
  logic                     hex1_we;

  assign busy       = (state != IDLE);
  assign io_hit     = (addr == IO_BASE) || (addr == IO_HEX1) || (addr == IO_LED);
  assign hex0_we    = (state == IO) && cur.we && (cur.addr == IO_BASE);
  assign hex1_we    = (state == IO) && cur.we && (cur.addr == IO_HEX1);
  assign hex_digits = hex_q;

`ifdef SW_SYNC_EN
  logic [DATA_W-1:0] sw_s1, sw_s2;
  // Two-stage synchronizer for the asynchronous board switches.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= Switches;
      sw_s2 <= sw_s1;
    end
  assign sw_val = sw_s2;
`else
  assign sw_val = Switches;
`endif

  // Digits 0..3 live in bank0 (IO_BASE), digits 4..7 in bank1 (IO_BASE-1).
  for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
    mem_io_hex_digit u_dig (
      .Clk   (Clk),
      .Reset (Reset),
      .we    ((i < 4) ? hex0_we : hex1_we),
      .d     (cur.wdata[4*(i%4) +: 4]),
      .q     (hex_q[i])
    );
  end

  // Gather bank1 digits for readback; missing digits read as zero.
  always_comb begin
    bank1 = '0;
    for (int i = 4; i < NUM_HEX; i++) bank1[4*(i-4) +: 4] = hex_q[i];
  end

  // I/O read mux for the latched address.
  always_comb begin
    io_rd = '0;
    if (cur.addr == IO_BASE)      io_rd = sw_val;
    else if (cur.addr == IO_HEX1) io_rd = DATA_W'(bank1);
    else                          io_rd = DATA_W'(LED);
  end

  // Access FSM with registered strobes, ack and read data.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state     <= IDLE;
      cur       <= '0;
      cnt       <= '0;
      ack       <= 1'b0;
      rdata     <= '0;
      LED       <= '0;
      mem_addr  <= '0;
      mem_ce_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_dq_oe <= 1'b0;
      mem_dq_o  <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: if (req) begin
          cur <= {we, addr, wdata};
          if (io_hit) begin
            state <= IO;
          end else begin
            state     <= MEM;
            cnt       <= WS;
            mem_addr  <= addr;
            mem_ce_n  <= 1'b0;
            mem_oe_n  <= we;
            mem_we_n  <= !we;
            mem_dq_oe <= we;
            if (we) mem_dq_o <= wdata;
          end
        end
        MEM: if (cnt == 4'd0) begin
          if (!cur.we) rdata <= mem_dq_i;
          mem_ce_n  <= 1'b1;
          mem_oe_n  <= 1'b1;
          mem_we_n  <= 1'b1;
          mem_dq_oe <= 1'b0;
          ack       <= 1'b1;
          state     <= DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        IO: begin
          if (cur.we) begin
            if (cur.addr == IO_LED) LED <= cur.wdata[11:0];
          end else begin
            rdata <= io_rd;
          end
          ack   <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: a WAIT_STATES=2 / NUM_HEX=6 instance
// with a small SRAM model, and a WAIT_STATES=0 instance for back-to-back use.
module tb_mem_io_bridge;
  localparam logic [19:0] IOB = 20'h0FFFF;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Main instance signals
  logic        req = 0, we = 0;
  logic [19:0] addr = '0;
  logic [15:0] wdata = '0, rdata, Switches = 16'h00A5;
  logic        ack, busy;
  logic [23:0] hex_digits;
  logic [11:0] LED;
  logic [19:0] mem_addr;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe;
  logic [15:0] mem_dq_o, mem_dq_i;

  // Zero-wait-state instance signals
  logic        req0 = 0, we0 = 0;
  logic [19:0] addr0 = '0;
  logic [15:0] wdata0 = '0, rdata0, dq_i0 = '0;
  logic        ack0, busy0;
  logic [15:0] hex_digits0;
  logic [11:0] LED0;
  logic [19:0] mem_addr0;
  logic        mem_ce_n0, mem_oe_n0, mem_we_n0, mem_dq_oe0;
  logic [15:0] mem_dq_o0;

  always #5 Clk = ~Clk;

  mem_io_bridge #(.DATA_W(16), .ADDR_W(20), .NUM_HEX(6), .WAIT_STATES(2), .IO_BASE(IOB)) u_dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .Switches(Switches),
    .hex_digits(hex_digits), .LED(LED), .mem_addr(mem_addr),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe), .mem_dq_i(mem_dq_i));

  mem_io_bridge #(.DATA_W(16), .ADDR_W(20), .NUM_HEX(4), .WAIT_STATES(0), .IO_BASE(IOB)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .Switches(Switches),
    .hex_digits(hex_digits0), .LED(LED0), .mem_addr(mem_addr0),
    .mem_ce_n(mem_ce_n0), .mem_oe_n(mem_oe_n0), .mem_we_n(mem_we_n0),
    .mem_dq_o(mem_dq_o0), .mem_dq_oe(mem_dq_oe0), .mem_dq_i(dq_i0));

  // Asynchronous-read SRAM model (256 words) behind the main instance.
  logic [15:0] sram [256];
  always_comb mem_dq_i = (!mem_ce_n && !mem_oe_n) ? sram[mem_addr[7:0]] : 16'h0000;
  always @(posedge Clk)
    if (!mem_ce_n && !mem_we_n && mem_dq_oe) sram[mem_addr[7:0]] <= mem_dq_o;

  // Scoreboard state
  logic [15:0] ref_mem [16];
  logic [23:0] hex_ref;
  logic [11:0] led_ref;

  // One handshake on the main instance; measures latency and strobe activity.
  task automatic access(input logic w, input logic [19:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int lat, output int ce_c,
                        output int oe_c, output int we_c, output bit bad);
    @(negedge Clk);
    req = 1; we = w; addr = a; wdata = d;
    lat = 0; ce_c = 0; oe_c = 0; we_c = 0; bad = 0;
    do begin
      @(negedge Clk);
      lat++;
      if (!mem_ce_n) ce_c++;
      if (!mem_oe_n) oe_c++;
      if (!mem_we_n) we_c++;
      if (!mem_ce_n && mem_addr !== a) bad = 1;
      if (!mem_we_n && (mem_dq_o !== d || !mem_dq_oe)) bad = 1;
    end while (!ack && lat < 40);
    if (!ack) lat = -1;
    req = 0;
    rd = rdata;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    checks++; if ({ack, busy, mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe} !== 6'b001110) begin
      errors++; $display("FAIL reset_ctl got %b exp 001110", {ack, busy, mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe}); end
    checks++; if ({rdata, mem_dq_o, mem_addr} !== 52'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {rdata, mem_dq_o, mem_addr}); end
    checks++; if ({hex_digits, LED} !== 36'h0) begin
      errors++; $display("FAIL reset_regs got %h exp 0", {hex_digits, LED}); end
    Reset = 0;
  endtask

  task automatic test_mem_read();
    logic [15:0] rd; int lat, ce_c, oe_c, we_c; bit bad;
    access(1'b1, 20'h00010, 16'hBEEF, rd, lat, ce_c, oe_c, we_c, bad);
    checks++; if ({lat, we_c, oe_c, 31'(bad)} !== {32'd4, 32'd3, 32'd0, 31'd0}) begin
      errors++; $display("FAIL mem_write lat %0d we %0d oe %0d bad %0d exp 4 3 0 0", lat, we_c, oe_c, bad); end
    access(1'b0, 20'h00010, 16'h0000, rd, lat, ce_c, oe_c, we_c, bad);
    checks++; if ({lat, oe_c, we_c, ce_c} !== {32'd4, 32'd3, 32'd0, 32'd3} || bad) begin
      errors++; $display("FAIL mem_read_timing lat %0d oe %0d we %0d ce %0d bad %0d exp 4 3 0 3 0", lat, oe_c, we_c, ce_c, bad); end
    checks++; if (rd !== 16'hBEEF) begin
      errors++; $display("FAIL mem_read_data got %h exp BEEF", rd); end
  endtask

  task automatic test_reset_mid();
    int acks;
    @(negedge Clk);
    req = 1; we = 1; addr = 20'h00080; wdata = 16'h5555;
    repeat (2) @(negedge Clk);
    Reset = 1;
    #1;
    checks++; if ({ack, busy, mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe} !== 6'b001110) begin
      errors++; $display("FAIL reset_mid_strobes got %b exp 001110", {ack, busy, mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe}); end
    req = 0;
    @(negedge Clk);
    Reset = 0;
    acks = 0;
    repeat (6) begin @(negedge Clk); if (ack || busy) acks++; end
    checks++; if (acks !== 0) begin
      errors++; $display("FAIL reset_mid_noack got %0d ack/busy cycles exp 0", acks); end
  endtask

  task automatic test_io();
    logic [15:0] rd; int lat, ce_c, oe_c, we_c; bit bad;
    access(1'b1, IOB, 16'h1234, rd, lat, ce_c, oe_c, we_c, bad);
    checks++; if ({lat, ce_c + oe_c + we_c} !== {32'd2, 32'd0}) begin
      errors++; $display("FAIL io_write_timing lat %0d strobes %0d exp 2 0", lat, ce_c + oe_c + we_c); end
    checks++; if (hex_digits !== 24'h001234) begin
      errors++; $display("FAIL io_hex0 got %h exp 001234", hex_digits); end
    access(1'b0, IOB, 16'h0000, rd, lat, ce_c, oe_c, we_c, bad);
    checks++; if ({rd, 16'(lat), 16'(ce_c + oe_c + we_c)} !== {16'h00A5, 16'd2, 16'd0}) begin
      errors++; $display("FAIL io_switch_read rd %h lat %0d strobes %0d exp 00A5 2 0", rd, lat, ce_c + oe_c + we_c); end
  endtask

  task automatic test_hex_led();
    logic [15:0] rd; int lat, ce_c, oe_c, we_c; bit bad;
    access(1'b1, IOB - 20'd1, 16'hABCD, rd, lat, ce_c, oe_c, we_c, bad);
    checks++; if (hex_digits !== 24'hCD1234) begin
      errors++; $display("FAIL hex_bank1 got %h exp CD1234", hex_digits); end
    access(1'b0, IOB - 20'd1, 16'h0000, rd, lat, ce_c, oe_c, we_c, bad);
    checks++; if (rd !== 16'h00CD) begin
      errors++; $display("FAIL hex_bank1_read got %h exp 00CD", rd); end
    access(1'b1, IOB - 20'd2, 16'hF0F0, rd, lat, ce_c, oe_c, we_c, bad);
    checks++; if (LED !== 12'h0F0) begin
      errors++; $display("FAIL led_write got %h exp 0F0", LED); end
    checks++; if (rdata !== 16'h00CD) begin
      errors++; $display("FAIL rdata_hold got %h exp 00CD", rdata); end
    access(1'b0, IOB - 20'd2, 16'h0000, rd, lat, ce_c, oe_c, we_c, bad);
    checks++; if ({rd, 16'(lat)} !== {16'h00F0, 16'd2}) begin
      errors++; $display("FAIL led_read rd %h lat %0d exp 00F0 2", rd, lat); end
  endtask

  task automatic test_req_drop();
    int lat;
    @(negedge Clk);
    req = 1; we = 0; addr = 20'h00010;
    @(negedge Clk);
    req = 0;
    lat = 1;
    while (!ack && lat < 40) begin @(negedge Clk); lat++; end
    checks++; if ({lat, 16'(rdata)} !== {32'd4, 16'hBEEF}) begin
      errors++; $display("FAIL req_drop lat %0d rd %h exp 4 BEEF", lat, rdata); end
  endtask

  task automatic test_random();
    logic [15:0] rd, d, exp; int lat, ce_c, oe_c, we_c, k, i; bit bad;
    logic [19:0] a;
    hex_ref = 24'hCD1234;
    led_ref = 12'h0F0;
    for (int j = 0; j < 16; j++) begin
      d = 16'($urandom);
      ref_mem[j] = d;
      access(1'b1, 20'h00040 + 20'(j), d, rd, lat, ce_c, oe_c, we_c, bad);
      checks++; if (lat !== 4 || bad) begin
        errors++; $display("FAIL rnd_fill[%0d] lat %0d bad %0d exp 4 0", j, lat, bad); end
    end
    for (int n = 0; n < 40; n++) begin
      Switches = 16'($urandom);
      repeat (3) @(negedge Clk);
      k = $urandom_range(0, 3);
      i = $urandom_range(0, 15);
      d = 16'($urandom);
      case (k)
        0: a = 20'h00040 + 20'(i);
        1: a = IOB;
        2: a = IOB - 20'd1;
        default: a = IOB - 20'd2;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        access(1'b1, a, d, rd, lat, ce_c, oe_c, we_c, bad);
        case (k)
          0: ref_mem[i] = d;
          1: hex_ref[15:0] = d;
          2: hex_ref[23:16] = d[7:0];
          default: led_ref = d[11:0];
        endcase
        checks++; if ({hex_digits, LED} !== {hex_ref, led_ref} || lat !== ((k == 0) ? 4 : 2) || bad) begin
          errors++; $display("FAIL rnd_write[%0d] a %h hex %h led %h lat %0d exp hex %h led %h lat %0d",
                             n, a, hex_digits, LED, lat, hex_ref, led_ref, (k == 0) ? 4 : 2); end
      end else begin
        access(1'b0, a, 16'h0000, rd, lat, ce_c, oe_c, we_c, bad);
        case (k)
          0: exp = ref_mem[i];
          1: exp = Switches;
          2: exp = {8'h00, hex_ref[23:16]};
          default: exp = {4'h0, led_ref};
        endcase
        checks++; if (rd !== exp || lat !== ((k == 0) ? 4 : 2) || bad) begin
          errors++; $display("FAIL rnd_read[%0d] a %h rd %h lat %0d exp %h lat %0d", n, a, rd, lat, exp, (k == 0) ? 4 : 2); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] ack_m, we_m, busy_m;
    ack_m = '0; we_m = '0; busy_m = '0;
    @(negedge Clk);
    req0 = 1; we0 = 1; addr0 = 20'h00020; wdata0 = 16'h1111;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (ack0) ack_m[c] = 1'b1;
      if (busy0) busy_m[c] = 1'b1;
      if (!mem_we_n0 && !mem_ce_n0 && mem_dq_o0 === ((c < 3) ? 16'h1111 : 16'h2222)) we_m[c] = 1'b1;
      if (c == 2) wdata0 = 16'h2222;
      if (c == 5) req0 = 0;
    end
    checks++; if (ack_m !== 9'b000100100) begin
      errors++; $display("FAIL b2b_ack got %b exp 000100100", ack_m); end
    checks++; if (we_m !== 9'b000010010) begin
      errors++; $display("FAIL b2b_write got %b exp 000010010", we_m); end
    checks++; if (busy_m !== 9'b000110110) begin
      errors++; $display("FAIL b2b_busy got %b exp 000110110", busy_m); end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_reset_mid();
    test_io();
    test_hex_led();
    test_req_drop();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
